// File: rtl/decoder_scan_controller.sv
// Select sequencer and registered 3-to-8 LED decoder stage with dwell prescaler.
// Optional build macro: DECODER_SCAN_BLANK_EN (blank the LEDs for one cycle on each sequenced step).
module decoder_scan_controller #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  load,
  input  logic [SEL_W-1:0]      load_sel,
  output logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   onehot,
  output logic                  step,
  output logic                  wrap
);

  localparam int OH_W = 2**SEL_W;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_PP   = 2'b11;

  localparam logic [SEL_W-1:0]   SEL_ZERO   = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0]   SEL_MAX    = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0]   SEL_ONE    = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] PRESC_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] PRESC_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [OH_W-1:0]    OH_ZERO    = {OH_W{1'b0}};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic [OH_W-1:0] decode_sel(input logic [SEL_W-1:0] s);
    decode_sel = {{(OH_W-1){1'b0}}, 1'b1} << s;
  endfunction

  dir_e                dir_r, dir_n;
  logic [SEL_W-1:0]    sel_r, sel_n;
  logic [DWELL_W-1:0]  presc_r, presc_n;
  logic [OH_W-1:0]     onehot_r, onehot_n;
  logic                step_r, step_n;
  logic                wrap_r, wrap_n;

  logic                expired_s;
  logic                advance_s;
  logic                pp_s;
  dir_e                eff_dir_s;
  logic [SEL_W-1:0]    sel_adv_s;

  // State register: direction FSM plus the registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r    <= DIR_UP;
      sel_r    <= SEL_ZERO;
      presc_r  <= PRESC_ZERO;
      onehot_r <= OH_ZERO;
      step_r   <= 1'b0;
      wrap_r   <= 1'b0;
    end else begin
      dir_r    <= dir_n;
      sel_r    <= sel_n;
      presc_r  <= presc_n;
      onehot_r <= onehot_n;
      step_r   <= step_n;
      wrap_r   <= wrap_n;
    end
  end

  // Shared qualifiers: dwell expiry, endpoint-forced direction and candidate select.
  always_comb begin
    expired_s = (presc_r >= dwell);
    advance_s = enable && !load && expired_s;
    pp_s      = (mode == MODE_PP);
    // Endpoints override the stored direction so ping-pong never walks off the range.
    if (sel_r == SEL_MAX) begin
      eff_dir_s = DIR_DOWN;
    end else if (sel_r == SEL_ZERO) begin
      eff_dir_s = DIR_UP;
    end else begin
      eff_dir_s = dir_r;
    end
    case (mode)
      MODE_HOLD: sel_adv_s = sel_r;
      MODE_UP:   sel_adv_s = sel_r + SEL_ONE;
      MODE_DOWN: sel_adv_s = sel_r - SEL_ONE;
      MODE_PP:   sel_adv_s = (eff_dir_s == DIR_UP) ? (sel_r + SEL_ONE) : (sel_r - SEL_ONE);
      default:   sel_adv_s = sel_r;
    endcase
  end

  // Next-state logic: ping-pong direction and dwell prescaler.
  always_comb begin
    dir_n   = dir_r;
    presc_n = presc_r;
    if (load) begin
      presc_n = PRESC_ZERO;
      if (pp_s && (load_sel == SEL_MAX)) begin
        dir_n = DIR_DOWN;
      end else if (pp_s && (load_sel == SEL_ZERO)) begin
        dir_n = DIR_UP;
      end else begin
        dir_n = dir_r;
      end
    end else if (!enable) begin
      dir_n   = dir_r;
      presc_n = presc_r;
    end else begin
      presc_n = expired_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
      if (pp_s && advance_s && (sel_adv_s == SEL_MAX)) begin
        dir_n = DIR_DOWN;
      end else if (pp_s && advance_s && (sel_adv_s == SEL_ZERO)) begin
        dir_n = DIR_UP;
      end else if (pp_s) begin
        dir_n = eff_dir_s;
      end else begin
        dir_n = dir_r;
      end
    end
  end

  // Output logic: next select, step/wrap pulses and the decoded LED drive.
  always_comb begin
    sel_n    = sel_r;
    step_n   = 1'b0;
    wrap_n   = 1'b0;
    onehot_n = OH_ZERO;
    if (load) begin
      sel_n = load_sel;
    end else if (advance_s) begin
      sel_n  = sel_adv_s;
      step_n = (mode != MODE_HOLD);
      case (mode)
        MODE_HOLD: wrap_n = 1'b0;
        MODE_UP:   wrap_n = (sel_r == SEL_MAX);
        MODE_DOWN: wrap_n = (sel_r == SEL_ZERO);
        MODE_PP:   wrap_n = (sel_adv_s == SEL_MAX) || (sel_adv_s == SEL_ZERO);
        default:   wrap_n = 1'b0;
      endcase
    end else begin
      sel_n = sel_r;
    end

    if (!enable) begin
      onehot_n = OH_ZERO;
    end else begin
`ifdef DECODER_SCAN_BLANK_EN
      // Dark for the step cycle; the new position lights one cycle later.
      onehot_n = step_n ? OH_ZERO : decode_sel(sel_n);
`else
      onehot_n = decode_sel(sel_n);
`endif
    end
  end

  assign sel    = sel_r;
  assign onehot = onehot_r;
  assign step   = step_r;
  assign wrap   = wrap_r;

endmodule

// File: tb/tb_decoder_scan_controller.sv
// Table-driven scoreboard bench for decoder_scan_controller; honours DECODER_SCAN_BLANK_EN.
module tb_decoder_scan_controller;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic       load;
  logic [2:0] load_sel;
  logic [2:0] sel;
  logic [7:0] onehot;
  logic       step;
  logic       wrap;

  decoder_scan_controller #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .mode     (mode),
    .dwell    (dwell),
    .load     (load),
    .load_sel (load_sel),
    .sel      (sel),
    .onehot   (onehot),
    .step     (step),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] md;
    logic [7:0] dw;
    logic       ld;
    logic [2:0] ls;
    logic [2:0] e_sel;
    logic [7:0] e_oh;
    logic       e_step;
    logic       e_wrap;
    string      tag;
  } vec_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] oh;
    logic       step;
    logic       wrap;
    string      tag;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic void add(input logic en, input logic [1:0] md, input logic [7:0] dw,
                              input logic ld, input logic [2:0] ls, input logic [2:0] es,
                              input logic [7:0] eo, input logic st, input logic wr,
                              input string tag);
    vec_t v;
    v.en = en; v.md = md; v.dw = dw; v.ld = ld; v.ls = ls;
    v.e_sel = es; v.e_oh = eo; v.e_step = st; v.e_wrap = wr; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag, input int idx, input string field,
                       input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s[%0d] %s: got 0x%0h, expected 0x%0h", tag, idx, field, got, want);
    end
  endtask

  // Drive each vector just after a falling edge, score it on the next falling edge.
  task automatic run_table(input int first, input int last);
    exp_t e;
    for (int i = first; i < last; i++) begin
      enable   = vecs[i].en;
      mode     = vecs[i].md;
      dwell    = vecs[i].dw;
      load     = vecs[i].ld;
      load_sel = vecs[i].ls;
      e.sel  = vecs[i].e_sel;
      e.oh   = vecs[i].e_oh;
      e.step = vecs[i].e_step;
      e.wrap = vecs[i].e_wrap;
      e.tag  = vecs[i].tag;
      e.idx  = i;
`ifdef DECODER_SCAN_BLANK_EN
      if (e.step) e.oh = 8'h00;
`endif
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard_underflow[%0d]: got empty queue, expected an entry", i);
      end else begin
        e = exp_q.pop_front();
        check(e.tag, e.idx, "sel",    {5'd0, sel},  {5'd0, e.sel});
        check(e.tag, e.idx, "onehot", onehot,       e.oh);
        check(e.tag, e.idx, "step",   {7'd0, step}, {7'd0, e.step});
        check(e.tag, e.idx, "wrap",   {7'd0, wrap}, {7'd0, e.wrap});
      end
    end
  endtask

  int n1;
  int s;
  int pos;

  initial begin
    // Up count after a load to 0, dwell 0: 0x01, 0x02 .. 0x80, 0x01.
    add(1'b1, 2'b01, 8'd0, 1'b1, 3'd0, 3'd0, 8'h01, 1'b0, 1'b0, "A_load0");
    for (int k = 1; k <= 8; k++) begin
      s = k % 8;
      add(1'b1, 2'b01, 8'd0, 1'b0, 3'd0, 3'(s), 8'h01 << s, 1'b1, (s == 0), "A_up");
    end
    // dwell 3: a change every 4 cycles; then dwell drops to 1 while prescaler is 3.
    for (int j = 1; j <= 11; j++) begin
      s = j / 4;
      add(1'b1, 2'b01, 8'd3, 1'b0, 3'd0, 3'(s), 8'h01 << s, ((j % 4) == 0), 1'b0, "B_dw3");
    end
    add(1'b1, 2'b01, 8'd1, 1'b0, 3'd0, 3'd3, 8'h08, 1'b1, 1'b0, "B_dw1");
    add(1'b1, 2'b01, 8'd1, 1'b0, 3'd0, 3'd3, 8'h08, 1'b0, 1'b0, "B_dw1");
    add(1'b1, 2'b01, 8'd1, 1'b0, 3'd0, 3'd4, 8'h10, 1'b1, 1'b0, "B_dw1");
    add(1'b1, 2'b01, 8'd1, 1'b0, 3'd0, 3'd4, 8'h10, 1'b0, 1'b0, "B_dw1");
    add(1'b1, 2'b01, 8'd1, 1'b0, 3'd0, 3'd5, 8'h20, 1'b1, 1'b0, "B_dw1");
    n1 = vecs.size();

    // Ping-pong from 0: 1..7,6..0,1 with wrap on arrival at 7 and at 0.
    add(1'b1, 2'b11, 8'd0, 1'b1, 3'd0, 3'd0, 8'h01, 1'b0, 1'b0, "C_load0");
    for (int k = 1; k <= 15; k++) begin
      pos = k % 14;
      s = (pos <= 7) ? pos : 14 - pos;
      add(1'b1, 2'b11, 8'd0, 1'b0, 3'd0, 3'(s), 8'h01 << s, 1'b1, (s == 7 || s == 0), "C_pp");
    end
    // Load while disabled, then down at dwell 1, then load on an expiry cycle.
    add(1'b0, 2'b10, 8'd1, 1'b1, 3'd6, 3'd6, 8'h00, 1'b0, 1'b0, "D_ld_dis");
    add(1'b0, 2'b10, 8'd1, 1'b0, 3'd0, 3'd6, 8'h00, 1'b0, 1'b0, "D_dis");
    add(1'b0, 2'b10, 8'd1, 1'b0, 3'd0, 3'd6, 8'h00, 1'b0, 1'b0, "D_dis");
    add(1'b1, 2'b10, 8'd1, 1'b0, 3'd0, 3'd6, 8'h40, 1'b0, 1'b0, "D_down");
    add(1'b1, 2'b10, 8'd1, 1'b0, 3'd0, 3'd5, 8'h20, 1'b1, 1'b0, "D_down");
    add(1'b1, 2'b10, 8'd1, 1'b0, 3'd0, 3'd5, 8'h20, 1'b0, 1'b0, "D_down");
    add(1'b1, 2'b10, 8'd1, 1'b1, 3'd2, 3'd2, 8'h04, 1'b0, 1'b0, "D_ld_exp");
    add(1'b1, 2'b10, 8'd1, 1'b0, 3'd0, 3'd2, 8'h04, 1'b0, 1'b0, "D_after_ld");
    add(1'b1, 2'b10, 8'd1, 1'b0, 3'd0, 3'd1, 8'h02, 1'b1, 1'b0, "D_after_ld");
    add(1'b0, 2'b10, 8'd1, 1'b0, 3'd0, 3'd1, 8'h00, 1'b0, 1'b0, "D_freeze");
    add(1'b1, 2'b10, 8'd1, 1'b0, 3'd0, 3'd1, 8'h02, 1'b0, 1'b0, "D_resume");
    // Hold for 20 cycles, then down wrap 0 -> 7.
    for (int k = 0; k < 20; k++) begin
      add(1'b1, 2'b00, 8'd0, 1'b0, 3'd0, 3'd1, 8'h02, 1'b0, 1'b0, "E_hold");
    end
    add(1'b1, 2'b10, 8'd0, 1'b1, 3'd0, 3'd0, 8'h01, 1'b0, 1'b0, "E_ld0");
    add(1'b1, 2'b10, 8'd0, 1'b0, 3'd0, 3'd7, 8'h80, 1'b1, 1'b1, "E_wrap");
    add(1'b1, 2'b10, 8'd0, 1'b0, 3'd0, 3'd6, 8'h40, 1'b1, 1'b0, "E_down");
    // Up at dwell 2; the blank build darkens each step cycle.
    add(1'b1, 2'b01, 8'd2, 1'b1, 3'd0, 3'd0, 8'h01, 1'b0, 1'b0, "F_load0");
    for (int j = 1; j <= 7; j++) begin
      s = j / 3;
      add(1'b1, 2'b01, 8'd2, 1'b0, 3'd0, 3'(s), 8'h01 << s, ((j % 3) == 0), 1'b0, "F_dw2");
    end
    // Entering ping-pong at 7 with dir up must turn down; load of 7 in ping-pong too.
    add(1'b1, 2'b01, 8'd0, 1'b1, 3'd7, 3'd7, 8'h80, 1'b0, 1'b0, "G_ld7");
    add(1'b1, 2'b11, 8'd0, 1'b0, 3'd0, 3'd6, 8'h40, 1'b1, 1'b0, "G_pp_in");
    add(1'b1, 2'b11, 8'd0, 1'b0, 3'd0, 3'd5, 8'h20, 1'b1, 1'b0, "G_pp_in");
    add(1'b1, 2'b11, 8'd0, 1'b1, 3'd7, 3'd7, 8'h80, 1'b0, 1'b0, "G_ldpp7");
    add(1'b1, 2'b11, 8'd0, 1'b0, 3'd0, 3'd6, 8'h40, 1'b1, 1'b0, "G_ldpp7");

    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; dwell = 8'd0; load = 1'b0; load_sel = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("por", 0, "sel",    {5'd0, sel},  8'h00);
    check("por", 0, "onehot", onehot,       8'h00);
    check("por", 0, "step",   {7'd0, step}, 8'h00);
    check("por", 0, "wrap",   {7'd0, wrap}, 8'h00);
    rst_n = 1'b1;
    run_table(0, n1);

    // Asynchronous reset mid-run at sel=5, observed before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, "sel",    {5'd0, sel},  8'h00);
    check("async_rst", 0, "onehot", onehot,       8'h00);
    check("async_rst", 0, "step",   {7'd0, step}, 8'h00);
    check("async_rst", 0, "wrap",   {7'd0, wrap}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold", 0, "sel",    {5'd0, sel}, 8'h00);
    check("rst_hold", 0, "onehot", onehot,      8'h00);
    rst_n = 1'b1;
    run_table(n1, vecs.size());

    check("scoreboard_drain", 0, "left", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
